// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one external FP32 adder between two requesters.
// Operands are registered, held for ADD_LAT cycles, and the captured sum is returned to its owner.
module fpadd_sched #(
    parameter int unsigned ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_res,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_res,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_res,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ADD_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rr;
    logic        owner_q;
    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res_q;
    logic        grant;
    logic        accept;
    logic        rsp_take;

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        grant = rr;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (req1_valid && !req0_valid)
            grant = 1'b1;
    end

    assign accept   = (state == IDLE) && !rst && (grant ? req1_valid : req0_valid);
    assign rsp_take = (state == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = CALC;
            CALC:    if (cnt == 4'd0)  state_nxt = RESP;
            RESP:    if (rsp_take)     state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // add_res is captured only on the last CALC edge, so earlier adder glitches never reach res_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr      <= 1'b0;
            owner_q <= 1'b0;
            cnt     <= 4'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            res_q   <= 32'd0;
        end else if (accept) begin
            op_a    <= grant ? req1_a : req0_a;
            op_b    <= grant ? req1_b : req0_b;
            owner_q <= grant;
            rr      <= ~grant;
            cnt     <= CNT_INIT;
        end else if (state == CALC) begin
            if (cnt == 4'd0)
                res_q <= add_res;
            else
                cnt <= cnt - 4'd1;
        end
    end

    // NOTE: every output is given a default first, so no path through this block can infer a latch.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_res   = 32'd0;
        rsp1_res   = 32'd0;
        add_a      = 32'd0;
        add_b      = 32'd0;
        busy       = 1'b0;
        owner      = 1'b0;
        if (!rst) begin
            req0_ready = (state == IDLE) && !grant;
            req1_ready = (state == IDLE) && grant;
            rsp0_valid = (state == RESP) && !owner_q;
            rsp1_valid = (state == RESP) && owner_q;
            rsp0_res   = res_q;
            rsp1_res   = res_q;
            add_a      = op_a;
            add_b      = op_b;
            busy       = (state != IDLE);
            owner      = owner_q;
        end
    end

endmodule
